// File: rtl/abp_sender.sv
// Alternating-bit protocol sender: buffers one frame from s_axis, sends it on m_axis
// behind a one-byte bit header and retransmits on timeout until a matching ack arrives.
module abp_sender #(
    parameter int unsigned TIMEOUT_DURATION = 10,
    parameter int unsigned MAX_FRAME_BYTES  = 16
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic [7:0] s_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic [7:0] m_axis_tdata,
    input  logic       ack_axis_tvalid,
    output logic       ack_axis_tready,
    input  logic       ack_axis_tlast,
    input  logic [7:0] ack_axis_tdata,
    output logic       current_bit,
    output logic       busy,
    output logic [7:0] retransmit_count,
    output logic       overflow
);
    localparam int unsigned LEN_W   = $clog2(MAX_FRAME_BYTES + 1);
    localparam int unsigned ADDR_W  = (MAX_FRAME_BYTES > 1) ? $clog2(MAX_FRAME_BYTES) : 1;
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_DURATION + 1);
    localparam logic [6:0]  ACK_TAG = 7'b1010101;

    typedef enum logic [1:0] {LOAD, DROP, SEND, WAIT_ACK} state_e;

    state_e               state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     idx_q, idx_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 cur_bit_q, cur_bit_d;
    logic [7:0]           rtx_cnt_q, rtx_cnt_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_last_q, m_last_d;
    logic [7:0]           m_data_q, m_data_d;
    logic                 overflow_q, overflow_d;
    logic                 busy_q, busy_d;
    logic                 s_rdy_q, s_rdy_d;
    logic                 ack_rdy_q, ack_rdy_d;
    logic [7:0]           buf_q [MAX_FRAME_BYTES];

    logic                 s_fire;
    logic                 m_fire;
    logic                 ack_ok;
    logic                 timeout;
    logic                 last_beat;
    logic                 wr_en;
    logic                 load_hdr;

    assign s_fire    = s_axis_tvalid & s_rdy_q;
    assign m_fire    = m_valid_q & m_axis_tready;
    assign ack_ok    = ack_axis_tvalid & ack_axis_tlast &
                       (ack_axis_tdata[7:1] == ACK_TAG) & (ack_axis_tdata[0] == cur_bit_q);
    assign timeout   = (timer_q == TIMER_W'(TIMEOUT_DURATION - 1));
    assign last_beat = (idx_q == len_q);

    // State register
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a valid ack outranks a coincident timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (s_fire) begin
                    if (s_axis_tlast) begin
                        state_d = SEND;
                    end else if (len_q == LEN_W'(MAX_FRAME_BYTES - 1)) begin
                        state_d = DROP;
                    end
                end
            end
            DROP:     if (s_fire && s_axis_tlast) state_d = SEND;
            SEND:     if (m_fire && last_beat) state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (ack_ok) begin
                    state_d = LOAD;
                end else if (timeout) begin
                    state_d = SEND;
                end
            end
            default:  state_d = LOAD;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        len_d      = len_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        cur_bit_d  = cur_bit_q;
        rtx_cnt_d  = rtx_cnt_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        m_data_d   = m_data_q;
        overflow_d = 1'b0;
        wr_en      = 1'b0;
        load_hdr   = 1'b0;
        case (state_q)
            LOAD: begin
                if (s_fire) begin
                    wr_en    = 1'b1;
                    len_d    = len_q + LEN_W'(1);
                    load_hdr = s_axis_tlast;
                end
            end
            DROP: begin
                if (s_fire) begin
                    overflow_d = 1'b1;
                    load_hdr   = s_axis_tlast;
                end
            end
            SEND: begin
                if (m_fire) begin
                    if (last_beat) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        timer_d   = '0;
                    end else begin
                        // idx_q is the beat on the bus; the next beat is buffer[idx_q]
                        idx_d    = idx_q + LEN_W'(1);
                        m_data_d = buf_q[idx_q[ADDR_W-1:0]];
                        m_last_d = ((idx_q + LEN_W'(1)) == len_q);
                    end
                end
            end
            WAIT_ACK: begin
                if (ack_ok) begin
                    cur_bit_d = ~cur_bit_q;
                    len_d     = '0;
                end else if (timeout) begin
                    load_hdr = 1'b1;
                    if (rtx_cnt_q != 8'hFF) begin
                        rtx_cnt_d = rtx_cnt_q + 8'd1;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: ;
        endcase
        if (load_hdr) begin
            m_valid_d = 1'b1;
            m_last_d  = 1'b0;
            m_data_d  = {7'b0000000, cur_bit_q};
            idx_d     = '0;
        end
        s_rdy_d   = (state_d == LOAD) || (state_d == DROP);
        busy_d    = (state_d != LOAD);
        ack_rdy_d = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            len_q      <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            cur_bit_q  <= 1'b0;
            rtx_cnt_q  <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            s_rdy_q    <= 1'b0;
            ack_rdy_q  <= 1'b0;
        end else begin
            len_q      <= len_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            cur_bit_q  <= cur_bit_d;
            rtx_cnt_q  <= rtx_cnt_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            m_data_q   <= m_data_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            s_rdy_q    <= s_rdy_d;
            ack_rdy_q  <= ack_rdy_d;
        end
    end

    // Payload storage needs no reset: len_q bounds every read
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            buf_q[len_q[ADDR_W-1:0]] <= s_axis_tdata;
        end
    end

    assign s_axis_tready    = s_rdy_q;
    assign ack_axis_tready  = ack_rdy_q;
    assign m_axis_tvalid    = m_valid_q;
    assign m_axis_tlast     = m_last_q;
    assign m_axis_tdata     = m_data_q;
    assign current_bit      = cur_bit_q;
    assign busy             = busy_q;
    assign retransmit_count = rtx_cnt_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_abp_sender.sv
// Directed bench for abp_sender: scoreboard of expected m_axis beats, plus timing
// checks on header latency, timeout, ack priority, overflow and reset.
module tb_abp_sender;
    localparam int MFB = 16;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       s_axis_tlast = 1'b0;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       m_axis_tlast;
    logic [7:0] m_axis_tdata;
    logic       ack_axis_tvalid = 1'b0;
    logic       ack_axis_tready;
    logic       ack_axis_tlast = 1'b0;
    logic [7:0] ack_axis_tdata = 8'h00;
    logic       current_bit;
    logic       busy;
    logic [7:0] retransmit_count;
    logic       overflow;

    logic [8:0] exp_q [$];
    logic [7:0] frm [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_e0 = 0;
    int         ovf_cnt = 0;
    bit         rand_rdy = 1'b0;
    logic       rdy_fixed = 1'b1;
    logic       exp_bit = 1'b0;
    int         exp_rtx = 0;

    abp_sender #(.TIMEOUT_DURATION(10), .MAX_FRAME_BYTES(MFB)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
        .ack_axis_tvalid(ack_axis_tvalid), .ack_axis_tready(ack_axis_tready),
        .ack_axis_tlast(ack_axis_tlast), .ack_axis_tdata(ack_axis_tdata),
        .current_bit(current_bit), .busy(busy),
        .retransmit_count(retransmit_count), .overflow(overflow)
    );

    initial forever #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // m_axis_tready: fixed level or random per cycle
    initial forever begin
        @(posedge aclk);
        #2;
        m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // Monitor: pops scoreboard on each accepted beat, checks stall stability, counts overflow
    initial begin : monitor
        logic       prev_stall;
        logic [8:0] held;
        logic [8:0] e;
        prev_stall = 1'b0;
        held = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                prev_stall = 1'b0;
            end else begin
                if (overflow) ovf_cnt++;
                if (prev_stall)
                    check("hold_stable", {22'b0, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                          {22'b0, 1'b1, held});
                if (m_axis_tvalid && m_axis_tready) begin
                    check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("m_beat", {23'b0, m_axis_tlast, m_axis_tdata}, {23'b0, e});
                        if (e[8]) last_e0 = cyc + 1;
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                held = {m_axis_tlast, m_axis_tdata};
            end
        end
    end

    task automatic do_reset();
        areset = 1'b1;
        @(posedge aclk); #1;
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        check("rst_ack_tready", 32'(ack_axis_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bit", 32'(current_bit), 32'd0);
        check("rst_rtx", 32'(retransmit_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        exp_bit = 1'b0;
        exp_rtx = 0;
        areset = 1'b0;
        @(posedge aclk); #1;
        check("rel_s_tready", 32'(s_axis_tready), 32'd1);
        check("rel_ack_tready", 32'(ack_axis_tready), 32'd1);
    endtask

    task automatic push_exp(input logic [7:0] data[$]);
        int n;
        n = (data.size() > MFB) ? MFB : data.size();
        exp_q.push_back({1'b0, 7'b0000000, exp_bit});
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), data[i]});
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        @(negedge aclk);
        while (!s_axis_tready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("s_accept", 32'(s_axis_tready), 32'd1);
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] data[$]);
        push_exp(data);
        for (int i = 0; i < data.size(); i++) push_byte(data[i], (i == data.size() - 1));
        check("hdr_next_cycle", {22'b0, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
              {22'b0, 1'b1, 1'b0, 7'b0000000, exp_bit});
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge aclk); #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_ack(input logic [7:0] d, input logic l);
        ack_axis_tvalid = 1'b1;
        ack_axis_tdata  = d;
        ack_axis_tlast  = l;
        @(posedge aclk); #1;
        ack_axis_tvalid = 1'b0;
        ack_axis_tlast  = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge aclk); #1;
        end
    endtask

    initial begin : main
        int   e0;
        int   n;
        logic seen;

        do_reset();

        // Unacked frame with bogus acks: ignored, resent exactly at timeout
        frm = '{8'h11, 8'h22};
        send_frame(frm);
        wait_drain(50);
        e0 = last_e0;
        push_exp(frm);
        wait_cyc(e0 + 2);
        send_ack(8'hAB, 1'b1);
        wait_cyc(e0 + 4);
        send_ack(8'hAA, 1'b0);
        wait_cyc(e0 + 9);
        check("no_early_rtx", 32'(m_axis_tvalid), 32'd0);
        @(posedge aclk); #1;
        exp_rtx++;
        check("rtx_hdr", {23'b0, m_axis_tvalid, m_axis_tdata}, {23'b0, 1'b1, 8'h00});
        check("rtx_count_1", 32'(retransmit_count), 32'(exp_rtx));
        check("bit_after_bad_ack", 32'(current_bit), 32'd0);
        wait_drain(50);
        send_ack(8'hAA, 1'b1);
        exp_bit = 1'b1;
        check("bit_after_ack", 32'(current_bit), 32'(exp_bit));
        check("busy_after_ack", 32'(busy), 32'd0);

        // Valid ack in the same cycle as the timeout: ack wins
        frm = '{8'h55, 8'h66, 8'h77};
        send_frame(frm);
        wait_drain(50);
        e0 = last_e0;
        wait_cyc(e0 + 9);
        send_ack(8'hAB, 1'b1);
        exp_bit = 1'b0;
        check("race_busy", 32'(busy), 32'd0);
        check("race_bit", 32'(current_bit), 32'(exp_bit));
        check("race_rtx", 32'(retransmit_count), 32'(exp_rtx));
        seen = 1'b0;
        repeat (15) begin
            @(posedge aclk); #1;
            if (m_axis_tvalid) seen = 1'b1;
        end
        check("race_no_rtx", 32'(seen), 32'd0);

        // 20-byte frame: truncated to 16, four overflow pulses
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(8'(8'h80 + i));
        ovf_cnt = 0;
        send_frame(frm);
        wait_drain(100);
        check("overflow_20", 32'(ovf_cnt), 32'd4);
        send_ack(8'hAA, 1'b1);
        exp_bit = 1'b1;
        check("bit_after_20", 32'(current_bit), 32'(exp_bit));

        // Exactly full buffer with tlast: no overflow
        frm.delete();
        for (int i = 0; i < 16; i++) frm.push_back(8'(8'hC0 + i));
        ovf_cnt = 0;
        send_frame(frm);
        wait_drain(100);
        check("overflow_16", 32'(ovf_cnt), 32'd0);
        send_ack(8'hAB, 1'b1);
        exp_bit = 1'b0;
        check("bit_after_16", 32'(current_bit), 32'(exp_bit));

        // Random backpressure
        frm.delete();
        for (int i = 0; i < 8; i++) frm.push_back(8'($urandom_range(0, 255)));
        rand_rdy = 1'b1;
        send_frame(frm);
        wait_drain(500);
        rand_rdy = 1'b0;
        send_ack(8'hAA, 1'b1);
        exp_bit = 1'b1;
        check("bit_after_rand", 32'(current_bit), 32'(exp_bit));

        // Retransmit counter saturation
        frm = '{8'h5A};
        send_frame(frm);
        wait_drain(50);
        repeat (256) begin
            push_exp(frm);
            wait_drain(40);
            exp_rtx = (exp_rtx == 255) ? 255 : exp_rtx + 1;
        end
        check("rtx_saturated", 32'(retransmit_count), 32'(exp_rtx));
        check("bit_unchanged", 32'(current_bit), 32'(exp_bit));

        // Reset while a retransmitted header is stalled on the bus
        rdy_fixed = 1'b0;
        n = 0;
        while (!m_axis_tvalid && n < 30) begin
            @(posedge aclk); #1;
            n++;
        end
        check("stalled_hdr", 32'(m_axis_tvalid), 32'd1);
        @(posedge aclk); #1;
        do_reset();
        rdy_fixed = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge aclk); #1;
            if (m_axis_tvalid) seen = 1'b1;
        end
        check("no_beat_after_reset", 32'(seen), 32'd0);

        // Recovery after reset
        frm = '{8'hE1, 8'hE2};
        send_frame(frm);
        wait_drain(50);
        send_ack(8'hAA, 1'b1);
        exp_bit = 1'b1;
        check("bit_after_recovery", 32'(current_bit), 32'(exp_bit));
        check("busy_after_recovery", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/abp_sender.md
ABP_SENDER -- requirements
Module: abp_sender

Interface
REQ-001 The block SHALL have parameter TIMEOUT_DURATION, default 10, meaning WAIT_ACK cycles before retransmission (legal range 1..65535).
REQ-002 The block SHALL have parameter MAX_FRAME_BYTES, default 16, meaning payload buffer depth in bytes (legal range 1..256).
REQ-003 aclk  input  1  sole clock; all logic on rising edge.
REQ-004 areset  input  1  reset, synchronous, active-high.
REQ-005 s_axis_tvalid/s_axis_tready/s_axis_tlast/s_axis_tdata  in/out/in/in  1/1/1/8  user payload stream, one frame per tlast.
REQ-006 m_axis_tvalid/m_axis_tready/m_axis_tlast/m_axis_tdata  out/in/out/out  1/1/1/8  channel-side data frames.
REQ-007 ack_axis_tvalid/ack_axis_tready/ack_axis_tlast/ack_axis_tdata  in/out/in/in  1/1/1/8  channel-side acknowledgement stream.
REQ-008 current_bit  output  1  alternating bit of the frame currently held.
REQ-009 busy  output  1  high in any state other than LOAD.
REQ-010 retransmit_count  output  8  saturating count of timeout retransmissions since reset.
REQ-011 overflow  output  1  one-cycle pulse when a payload byte is discarded for exceeding MAX_FRAME_BYTES.

Function
REQ-012 The FSM SHALL have states LOAD, DROP, SEND, WAIT_ACK.
REQ-013 LOAD: s_axis_tready=1; each accepted byte written to buffer[len], len incremented.
REQ-014 LOAD: byte accepted with tlast -> SEND next cycle, frame length = len+1.
REQ-015 LOAD: byte accepted without tlast filling the buffer (len reaches MAX_FRAME_BYTES) -> DROP.
REQ-016 DROP: s_axis_tready=1, bytes discarded with overflow pulsed per byte; byte with tlast -> SEND.
REQ-017 SEND: frame = header byte {7'b0000000, current_bit} then buffer[0..len-1]; m_axis_tlast only on final payload byte.
REQ-018 SEND: m_axis_tvalid/tdata/tlast SHALL be registered and held stable until m_axis_tready; no bubbles while tready stays high.
REQ-019 First header SHALL be valid the cycle after the tlast byte is accepted on s_axis.
REQ-020 Final beat accepted -> WAIT_ACK, timer cleared to 0.
REQ-021 ack_axis_tready SHALL be 1 in every state after reset; acks outside WAIT_ACK are consumed and ignored.
REQ-022 Valid ack: ack_axis_tvalid=1, ack_axis_tlast=1, tdata[7:1]=7'b1010101, tdata[0]=current_bit; any other ack beat ignored.
REQ-023 WAIT_ACK, valid ack -> current_bit toggles, len=0, LOAD next cycle.
REQ-024 WAIT_ACK: timer increments each cycle; timer = TIMEOUT_DURATION-1 with no valid ack -> SEND (same buffer, same bit), retransmit_count+1 saturating at 255.
REQ-025 Valid ack and timeout in the same cycle: ack SHALL win; no retransmission.
REQ-026 Timer width SHALL be $clog2(TIMEOUT_DURATION+1) bits; it never wraps.
REQ-027 m_axis_tready low during SEND SHALL not advance the timer (timer runs only in WAIT_ACK).

Reset
REQ-028 areset high at a rising edge SHALL force: state LOAD, len 0, timer 0, current_bit 0, retransmit_count 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, overflow 0, busy 0.
REQ-029 Reset mid-SEND SHALL drop the frame immediately; no partial beat presented after reset.
REQ-030 s_axis_tready and ack_axis_tready SHALL be 0 while areset is high, 1 the first cycle after release.

Verification
REQ-031 Frame 8'h11,8'h22 (tlast), m_axis_tready=1 -> m_axis 8'h00, 8'h11, 8'h22(tlast); ack 8'hAA -> current_bit=1, busy=0.
REQ-032 Same frame, no ack -> identical 3 beats resent 10 cycles after entering WAIT_ACK; retransmit_count=1.
REQ-033 Ack 8'hAB while current_bit=0, then timeout -> ack ignored, retransmission occurs.
REQ-034 20-byte frame, MAX_FRAME_BYTES=16 -> 4 overflow pulses; m_axis sends header + first 16 bytes, tlast on byte 16.
REQ-035 Valid ack coincident with timer=9 -> LOAD next cycle, no retransmit, count unchanged.
REQ-036 m_axis_tready toggled randomly -> each beat held stable until accepted, order preserved.
